// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_pkg
// Purpose  : Shared constants and state encoding for the sideband RX path.
// Revision : 1.0 - initial release
// ============================================================================
package sb_pkg;

    localparam int          SB_WORD_W       = 64;
    localparam int          SB_MIN_GAP      = 32;
    localparam logic [63:0] SB_INIT_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

    typedef enum logic [1:0] {
        SB_RX_IDLE  = 2'd0,
        SB_RX_SHIFT = 2'd1,
        SB_RX_GAP   = 2'd2
    } sb_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sb_rx_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : sb_rx_shift_reg
// Purpose  : LSB-first serial-to-parallel shifter with a load-to-output strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sb_rx_shift_reg
    import sb_pkg::*;
#(
    parameter int WORD_W = SB_WORD_W
) (
    input  logic              i_pll_clk,
    input  logic              i_rst_n,
    input  logic              i_shift_en,
    input  logic              i_load,
    input  logic              i_bit,
    output logic [WORD_W-1:0] o_par_data
);

    // Only WORD_W-1 bits are stored; the final bit is taken straight from the
    // line when the word is loaded, so the shifter never holds a dead bit.
    logic [WORD_W-2:0] r_shift;
    logic [WORD_W-1:0] r_par_data;
    logic [WORD_W-1:0] w_word;

    assign w_word     = {i_bit, r_shift};
    assign o_par_data = r_par_data;

    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_par_data <= '0;
        end else begin
            if (i_shift_en) begin
                r_shift <= w_word[WORD_W-1:1];
            end
            if (i_load) begin
                r_par_data <= w_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sb_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sb_rx_deserializer
// Purpose  : Sideband RX deserializer with 64-active / 32-idle framing checks.
//            Define SB_RX_PATTERN_DET_EN to add SBINIT pattern detection.
// Revision : 1.0 - initial release
// ============================================================================
module sb_rx_deserializer
    import sb_pkg::*;
#(
    parameter int WORD_W  = SB_WORD_W,
    parameter int MIN_GAP = SB_MIN_GAP
) (
    input  logic              i_pll_clk,
    input  logic              i_rst_n,
    input  logic              i_rxcksb_en,
    input  logic              i_rxdatasb,
    output logic [WORD_W-1:0] o_par_data,
    output logic              o_de_ser_done,
    output logic              o_frame_err,
    output logic              o_gap_err,
    output logic              o_rx_busy
`ifdef SB_RX_PATTERN_DET_EN
    ,
    output logic              o_pattern_det
`endif
);

    localparam int c_BIT_CNT_W = $clog2(WORD_W + 1);
    localparam int c_GAP_CNT_W = $clog2(MIN_GAP + 1);

    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(WORD_W - 1);
    localparam logic [c_GAP_CNT_W-1:0] c_GAP_MAX  = c_GAP_CNT_W'(MIN_GAP);

    sb_rx_state_t             r_state;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt;
    logic [c_GAP_CNT_W-1:0]   r_gap_cnt;
    logic                     r_done;
    logic                     r_frame_err;
    logic                     r_gap_err;

    logic [c_GAP_CNT_W-1:0]   w_gap_inc;
    logic                     w_load;
    logic [WORD_W-1:0]        w_par_data;

    assign w_gap_inc = r_gap_cnt + c_GAP_CNT_W'(1);
    assign w_load    = (r_state == SB_RX_SHIFT) && i_rxcksb_en && (r_bit_cnt == c_LAST_BIT);

    // Every qualified bit is captured, whichever state it arrives in.
    sb_rx_shift_reg #(
        .WORD_W     (WORD_W)
    ) u_shift_reg (
        .i_pll_clk  (i_pll_clk),
        .i_rst_n    (i_rst_n),
        .i_shift_en (i_rxcksb_en),
        .i_load     (w_load),
        .i_bit      (i_rxdatasb),
        .o_par_data (w_par_data)
    );

    always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= SB_RX_IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_gap_err   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_gap_err   <= 1'b0;
            case (r_state)
                SB_RX_IDLE: begin
                    if (i_rxcksb_en) begin
                        r_bit_cnt <= c_BIT_CNT_W'(1);
                        r_state   <= SB_RX_SHIFT;
                    end
                end
                SB_RX_SHIFT: begin
                    if (!i_rxcksb_en) begin
                        r_frame_err <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_state     <= SB_RX_IDLE;
                    end else if (r_bit_cnt == c_LAST_BIT) begin
                        r_done    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
                        r_state   <= SB_RX_GAP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_BIT_CNT_W'(1);
                    end
                end
                SB_RX_GAP: begin
                    if (i_rxcksb_en) begin
                        // Early start: flag it, but keep the bit as bit 0 of a new word.
                        r_gap_err <= (r_gap_cnt < c_GAP_MAX);
                        r_bit_cnt <= c_BIT_CNT_W'(1);
                        r_state   <= SB_RX_SHIFT;
                    end else begin
                        if (r_gap_cnt != c_GAP_MAX) begin
                            r_gap_cnt <= w_gap_inc;
                        end
                        if (w_gap_inc >= c_GAP_MAX) begin
                            r_state <= SB_RX_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= SB_RX_IDLE;
                end
            endcase
        end
    end

    assign o_par_data    = w_par_data;
    assign o_de_ser_done = r_done;
    assign o_frame_err   = r_frame_err;
    assign o_gap_err     = r_gap_err;
    assign o_rx_busy     = (r_state == SB_RX_SHIFT);

`ifdef SB_RX_PATTERN_DET_EN
    assign o_pattern_det = r_done && (w_par_data == WORD_W'(SB_INIT_PATTERN));
`endif

endmodule
`default_nettype wire

// File: tb/tb_sb_rx_deserializer.sv
`default_nettype none
// Directed self-checking bench for sb_rx_deserializer.
module tb_sb_rx_deserializer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        din;
    logic [63:0] par_data;
    logic        done;
    logic        frame_err;
    logic        gap_err;
    logic        busy;
`ifdef SB_RX_PATTERN_DET_EN
    logic        pattern_det;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sb_rx_deserializer dut (
        .i_pll_clk     (clk),
        .i_rst_n       (rst_n),
        .i_rxcksb_en   (en),
        .i_rxdatasb    (din),
        .o_par_data    (par_data),
        .o_de_ser_done (done),
        .o_frame_err   (frame_err),
        .o_gap_err     (gap_err),
        .o_rx_busy     (busy)
`ifdef SB_RX_PATTERN_DET_EN
        ,
        .o_pattern_det (pattern_det)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and sample #1 after the capturing edge.
    task automatic tick(input logic e, input logic d);
        @(negedge clk);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] w, input logic exp_gap, input string tag);
        int spurious;
        spurious = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, w[i]);
            if (i == 0) begin
                chk({tag, "_gap_err_first_bit"}, {63'd0, gap_err}, {63'd0, exp_gap});
                chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
            end else if (i < 63) begin
                if (done || frame_err || gap_err) spurious++;
            end
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_data"}, par_data, w);
        chk({tag, "_no_err"}, {62'd0, frame_err, gap_err}, 64'd0);
        chk({tag, "_mid_word_pulses"}, 64'(spurious), 64'd0);
`ifdef SB_RX_PATTERN_DET_EN
        chk({tag, "_pattern_det"}, {63'd0, pattern_det},
            {63'd0, (w == 64'hAAAA_AAAA_AAAA_AAAA)});
`endif
    endtask

    task automatic idle(input int n, input string tag);
        int spurious;
        spurious = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)));
            if (done || frame_err || gap_err) spurious++;
        end
        chk({tag, "_idle_pulses"}, 64'(spurious), 64'd0);
    endtask

    task automatic partial(input logic [63:0] w, input int n, input string tag);
        int spurious;
        spurious = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b1, w[i]);
            if (done || frame_err || gap_err) spurious++;
        end
        chk({tag, "_partial_pulses"}, 64'(spurious), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", par_data, 64'd0);
        chk("reset_flags", {60'd0, done, frame_err, gap_err, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, then exactly MIN_GAP idle cycles, then a legal second word
        send_word(64'h0123_4567_89AB_CDEF, 1'b0, "word_a");
        tick(1'b0, 1'b1);
        chk("word_a_done_one_cycle", {63'd0, done}, 64'd0);
        chk("word_a_busy_in_gap", {63'd0, busy}, 64'd0);
        idle(31, "gap_32");
        send_word(64'hFFFF_0000_FFFF_0000, 1'b0, "word_b");

        // Gap violations: 20 idle cycles, then the one-short boundary of 31
        idle(20, "gap_20");
        send_word(64'h0000_0000_0000_0001, 1'b1, "word_one");
        idle(31, "gap_31");
        send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b1, "word_c");
        idle(32, "gap_c");

        // Frame error after 40 bits: data held, next word starts without gap check
        partial(64'h1234_5678_9ABC_DEF0, 40, "frame40");
        tick(1'b0, 1'b1);
        chk("frame40_err", {63'd0, frame_err}, 64'd1);
        chk("frame40_data_held", par_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("frame40_flags", {61'd0, done, gap_err, busy}, 64'd0);
        tick(1'b0, 1'b0);
        chk("frame40_err_one_cycle", {63'd0, frame_err}, 64'd0);
        send_word(64'h5A5A_0F0F_3C3C_9669, 1'b0, "word_d");
        idle(32, "gap_d");

        // Frame error on the last possible bit position
        partial(64'hFFFF_FFFF_FFFF_FFFF, 63, "frame63");
        tick(1'b0, 1'b0);
        chk("frame63_err", {63'd0, frame_err}, 64'd1);
        chk("frame63_data_held", par_data, 64'h5A5A_0F0F_3C3C_9669);
        chk("frame63_no_done", {63'd0, done}, 64'd0);
        send_word(64'h8000_0000_0000_0001, 1'b0, "word_e");
        idle(32, "gap_e");

        // Asynchronous reset mid-word
        partial(64'h0F0F_0F0F_0F0F_0F0F, 30, "rst30");
        chk("rst30_busy_before", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst30_data", par_data, 64'd0);
        chk("rst30_flags", {60'd0, done, frame_err, gap_err, busy}, 64'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_word(64'hF0E1_D2C3_B4A5_9687, 1'b0, "word_f");

`ifdef SB_RX_PATTERN_DET_EN
        idle(32, "gap_f");
        send_word(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, "pat_aaaa");
        idle(32, "gap_pat");
        send_word(64'h5555_5555_5555_5555, 1'b0, "pat_5555");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_rx_deserializer.md
Name: sb_rx_deserializer

Overview:
- Sideband receive-side counterpart of the TX clock controller and serializer.
- Accepts the serial RXDATASB stream one bit per i_pll_clk cycle, qualified by i_rxcksb_en. i_rxcksb_en is high for each cycle in which the forwarded, gated RXCKSB pulse is present; it is generated by the sideband PHY front end.
- Assembles 64-bit words, checks the 64-active / 32-idle framing that TX produces, and hands completed words to the sideband link logic.
- Optionally detects the SBINIT clock pattern word.

Parameters:
- WORD_W, 64, bits per serialized word.
- MIN_GAP, 32, minimum idle (unqualified) cycles required between words.

Ports:
- i_pll_clk  in  1  RX sideband clock, 800 MHz.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rxcksb_en  in  1  bit-valid qualifier; high = RXCKSB pulse present this cycle.
- i_rxdatasb  in  1  serial data; sampled on the rising edge when i_rxcksb_en=1.
- o_par_data  out  WORD_W  last completed word; held until the next word completes.
- o_de_ser_done  out  1  one-cycle pulse: o_par_data updated.
- o_frame_err  out  1  one-cycle pulse: qualifier dropped mid-word.
- o_gap_err  out  1  one-cycle pulse: new word started before MIN_GAP idle cycles.
- o_rx_busy  out  1  high while in SHIFT state.
- o_pattern_det  out  1  (macro only) one-cycle pulse: completed word matches the SBINIT pattern.

Behaviour:
- Reset: all outputs 0, o_par_data=0, FSM=IDLE, bit counter=0, gap counter=0, shift register=0.
- Bit order: LSB first. The first qualified bit lands in o_par_data[0] and the 64th in [63].
- Counters: bit_cnt is $clog2(WORD_W+1) bits wide; gap_cnt is $clog2(MIN_GAP+1) bits wide and saturates at MIN_GAP.
- FSM IDLE:
  - en=1: capture bit 0, bit_cnt=1, go to SHIFT.
  - en=0: stay in IDLE.
- FSM SHIFT:
  - en=1: shift in the bit, bit_cnt+1.
  - On the 64th bit (bit_cnt==63 and en=1): register the full word into o_par_data and pulse o_de_ser_done on the next cycle (latency 1 cycle after the last bit edge). Then go to GAP with gap_cnt=0.
  - en=0 with 1<=bit_cnt<=63: pulse o_frame_err, discard the partial word (o_par_data unchanged), go to IDLE.
  - IDLE is used here, not GAP, so the next valid bit starts a word without a gap check.
- FSM GAP:
  - en=0: gap_cnt+1, saturating. When gap_cnt reaches MIN_GAP, go to IDLE.
  - en=1 with gap_cnt<MIN_GAP: pulse o_gap_err. The bit is still captured as bit 0 of a new word (bit_cnt=1) and the FSM goes to SHIFT.
  - A gap of exactly MIN_GAP idle cycles followed by en=1 is legal (no error).
- o_rx_busy = (state==SHIFT).
- Simultaneous events: o_de_ser_done and o_gap_err never coincide, because the gap check happens only after a completed word. o_frame_err has priority over everything else in SHIFT.
- Reset mid-word: immediate return to the reset state; the partial word is lost and no pulses are issued.
- i_rxdatasb is ignored whenever i_rxcksb_en=0.

Optional Feature:
- Macro: SB_RX_PATTERN_DET_EN.
- Defined:
  - Port o_pattern_det exists.
  - It pulses in the same cycle as o_de_ser_done when the completed word == 64'hAAAA_AAAA_AAAA_AAAA (SBINIT alternating pattern, LSB-first, so bit 0 = 0).
  - o_de_ser_done still pulses for that word.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package sb_pkg holds:
  - SB_WORD_W = 64.
  - SB_MIN_GAP = 32.
  - SB_INIT_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA.
  - typedef enum logic [1:0] {SB_RX_IDLE, SB_RX_SHIFT, SB_RX_GAP} sb_rx_state_t.
- One sub-module: sb_rx_shift_reg (WORD_W LSB-first shift register with load-to-output strobe). FSM and counters stay in the top.

Test Plan:
- Single word: 64 qualified bits encoding 64'h0123_4567_89AB_CDEF LSB-first -> o_par_data=64'h0123_4567_89AB_CDEF and a one-cycle o_de_ser_done exactly 1 cycle after the 64th bit; no errors.
- Back-to-back legal: word A, exactly 32 idle cycles, word B=64'hFFFF_0000_FFFF_0000 -> two o_de_ser_done pulses, o_gap_err never asserted.
- Gap violation: word, 20 idle cycles, next word 64'h1 -> o_gap_err pulse on the first bit of the second word; after 64 bits, o_par_data=64'h1 with o_de_ser_done.
- Frame error: 40 qualified bits, then en low -> o_frame_err pulse; o_par_data keeps its previous value; the next full 64-bit word completes normally.
- Reset mid-word: assert i_rst_n low after 30 bits -> all outputs 0 immediately, state IDLE; a fresh 64-bit word after reset decodes correctly.
- Pattern (SB_RX_PATTERN_DET_EN defined): send 64'hAAAA_AAAA_AAAA_AAAA -> o_pattern_det and o_de_ser_done in the same cycle. Sending 64'h5555_5555_5555_5555 -> no o_pattern_det.
